// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM states and default timing.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int LONG_CYCLES_DEF     = 50000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing one asynchronous bit into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: level, press/release/long-press strobes and a press counter,
// all driven from the synchronized button and registered before leaving the block.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_ARM  = CNT_W'(LONG_CYCLES - 2);

    logic             btn_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic [7:0]       count_q;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn),
        .q_o   (btn_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            if (press_d) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Strobes are decided alongside the transition so they land in the first cycle of the new state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    timer_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    timer_d     = '0;
                    press_d     = 1'b1;
                    long_done_d = 1'b0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    timer_d = '0;
                end else begin
                    if (timer_q != LONG_LAST) begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                    if ((timer_q == LONG_ARM) && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                // A release glitch returns to PRESSED keeping the short release timer value.
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (timer_q == DEB_LAST) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    release_d = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: expected strobes are queued with their due cycle
// when the button is driven and matched as the DUT emits them.
module tb_btn_debounce;

    localparam int DEB       = 4;
    localparam int LONG      = 10;
    localparam int PRESS_LAT = DEB + 3;
    localparam int LONG_LAT  = PRESS_LAT + LONG - 1;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    typedef struct {
        int kind;
        int cyc;
        int count;
    } expEvent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int         cyc = 0;
    int         nCompared = 0;
    int         nMismatched = 0;
    int         pressSeen = 0;
    int         releaseSeen = 0;
    int         longSeen = 0;
    int         expCount = 0;
    expEvent_t  expQ[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic expectEvent(input int kind, input int delay, input int count);
        expEvent_t e;
        e.kind  = kind;
        e.cyc   = cyc + delay;
        e.count = count;
        expQ.push_back(e);
    endtask

    task automatic matchEvent(input int kind, input int count);
        expEvent_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedEvent", kind, -1);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", kind, e.kind);
            checkOutput("eventCycle", cyc, e.cyc);
            if (kind == EV_PRESS) begin
                checkOutput("pressCount", count, e.count);
            end
        end
    endtask

    always @(negedge clk) begin
        if (press_pulse) begin
            pressSeen++;
            matchEvent(EV_PRESS, int'(press_count));
        end
        if (release_pulse) begin
            releaseSeen++;
            matchEvent(EV_RELEASE, 0);
        end
        if (long_pulse) begin
            longSeen++;
            matchEvent(EV_LONG, 0);
        end
    end

    task automatic applyStimulus(input logic level, input int holdCycles);
        btn = level;
        repeat (holdCycles) @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expCount = 0;
        applyStimulus(1'b0, 2);
    endtask

    initial begin
        int pressBase;
        int releaseBase;
        int longBase;

        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstLevel", int'(btn_level), 0);
        checkOutput("rstPress", int'(press_pulse), 0);
        checkOutput("rstRelease", int'(release_pulse), 0);
        checkOutput("rstLong", int'(long_pulse), 0);
        checkOutput("rstCount", int'(press_count), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3);

        // Clean 20-cycle press with one long-press event.
        expCount++;
        expectEvent(EV_PRESS, PRESS_LAT, expCount);
        expectEvent(EV_LONG, LONG_LAT, 0);
        applyStimulus(1'b1, 20);
        checkOutput("cleanLevelHeld", int'(btn_level), 1);
        expectEvent(EV_RELEASE, PRESS_LAT, 0);
        applyStimulus(1'b0, 6);
        checkOutput("cleanLevelLast", int'(btn_level), 1);
        applyStimulus(1'b0, 1);
        checkOutput("cleanLevelDrop", int'(btn_level), 0);
        applyStimulus(1'b0, 5);
        checkOutput("cleanCount", int'(press_count), 1);

        // Bouncing contact never accepted.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 1);
            checkOutput("bounceLevel", int'(btn_level), 0);
        end
        applyStimulus(1'b0, 10);
        checkOutput("bounceLevelAfter", int'(btn_level), 0);
        checkOutput("bounceCount", int'(press_count), 1);

        // Short low glitch while pressed is rejected.
        expCount++;
        expectEvent(EV_PRESS, PRESS_LAT, expCount);
        applyStimulus(1'b1, 9);
        checkOutput("glitchPreLevel", int'(btn_level), 1);
        applyStimulus(1'b0, 2);
        checkOutput("glitchLevel", int'(btn_level), 1);
        applyStimulus(1'b1, 4);
        checkOutput("glitchPostLevel", int'(btn_level), 1);
        expectEvent(EV_RELEASE, PRESS_LAT, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1);
            checkOutput("glitchRelHold", int'(btn_level), 1);
        end
        applyStimulus(1'b0, 1);
        checkOutput("glitchRelDone", int'(btn_level), 0);
        applyStimulus(1'b0, 3);
        checkOutput("glitchCount", int'(press_count), 2);

        // Reset while held: no release, held button re-debounced as a new press.
        expCount++;
        expectEvent(EV_PRESS, PRESS_LAT, expCount);
        applyStimulus(1'b1, 12);
        checkOutput("preRstLevel", int'(btn_level), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstLevel", int'(btn_level), 0);
        checkOutput("midRstCount", int'(press_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expCount = 1;
        expectEvent(EV_PRESS, PRESS_LAT, expCount);
        applyStimulus(1'b1, 10);
        checkOutput("reLevel", int'(btn_level), 1);
        expectEvent(EV_RELEASE, PRESS_LAT, 0);
        applyStimulus(1'b0, 12);
        checkOutput("reCount", int'(press_count), 1);

        // 256 short presses wrap the counter, no long presses.
        applyReset();
        checkOutput("wrapStartCount", int'(press_count), 0);
        pressBase   = pressSeen;
        releaseBase = releaseSeen;
        longBase    = longSeen;
        for (int i = 0; i < 256; i++) begin
            expCount = (expCount + 1) % 256;
            expectEvent(EV_PRESS, PRESS_LAT, expCount);
            applyStimulus(1'b1, 8);
            expectEvent(EV_RELEASE, PRESS_LAT, 0);
            applyStimulus(1'b0, 8);
        end
        applyStimulus(1'b0, 10);
        checkOutput("wrapPresses", pressSeen - pressBase, 256);
        checkOutput("wrapReleases", releaseSeen - releaseBase, 256);
        checkOutput("wrapLongs", longSeen - longBase, 0);
        checkOutput("wrapFinalCount", int'(press_count), 0);
        checkOutput("pendingEvents", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
